// File: rtl/mario_obj_dma_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mario_obj_dma_pkg : state encoding and default geometry for the object DMA.
// Rev 1.0
// ----------------------------------------------------------------------------
package mario_obj_dma_pkg;

  localparam int          IDX_W        = 10;
  localparam logic [15:0] DEF_SRC_BASE = 16'h6900;
  localparam int          DEF_LEN      = 384;
  localparam int          DEF_TIMEOUT  = 1023;

  typedef logic [2:0] dma_state_t;

  localparam dma_state_t ST_IDLE  = 3'd0;
  localparam dma_state_t ST_REQ   = 3'd1;
  localparam dma_state_t ST_ADDR  = 3'd2;
  localparam dma_state_t ST_READ  = 3'd3;
  localparam dma_state_t ST_WRITE = 3'd4;
  localparam dma_state_t ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mario_obj_dma_trig.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mario_obj_dma_trig : VBLKn falling-edge trigger with a single-entry pending latch.
// Rev 1.0
// ----------------------------------------------------------------------------
module mario_obj_dma_trig (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vblk_n_i,
  input  logic dma_en_i,
  input  logic clr_i,
  output logic pending_o
);

  logic vblk_n_q;
  logic pending_q;
  logic pending_d;

  // Reset low so a blank already in progress at reset release is not taken as an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vblk_n_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      vblk_n_q  <= vblk_n_i;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (vblk_n_q && !vblk_n_i && dma_en_i) begin
      pending_d = 1'b1;
    end
    if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: rtl/mario_obj_dma_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mario_obj_dma_ctrl : per-frame sprite table copy from the CPU bus to object RAM.
// Optional bus-grant timeout: define MARIO_OBJDMA_TIMEOUT_EN.      Rev 1.0
// ----------------------------------------------------------------------------
module mario_obj_dma_ctrl
  import mario_obj_dma_pkg::*;
#(
  parameter logic [15:0] SRC_BASE = DEF_SRC_BASE,
  parameter int          LEN      = DEF_LEN,
  parameter int          TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        I_CLK_48M,
  input  logic        I_RESET,
  input  logic        I_CEN_6M,
  input  logic        I_DMA_EN,
  input  logic        I_VBLKn,
  input  logic        I_BUSAKn,
  input  logic [7:0]  I_CPU_DI,
  output logic        O_BUSRQn,
  output logic [15:0] O_CPU_A,
  output logic        O_CPU_RDn,
  output logic [9:0]  O_OBJDMA_A,
  output logic [7:0]  O_OBJDMA_D,
  output logic        O_OBJDMA_CE,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_ERR
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  if (LEN < 1 || LEN > 1024 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mario_obj_dma_ctrl: LEN must be 1..1024 and TIMEOUT at least 1");
  end

  dma_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      cpu_a_q, cpu_a_d;
  logic             busrq_n_q, busrq_n_d;
  logic             rd_n_q, rd_n_d;
  logic             done_q, done_d;
  logic             pend;
  logic             pend_clr;
  logic             granted;
  logic             abort;

  mario_obj_dma_trig u_trig (
    .clk_i     (I_CLK_48M),
    .rst_i     (I_RESET),
    .vblk_n_i  (I_VBLKn),
    .dma_en_i  (I_DMA_EN),
    .clr_i     (pend_clr),
    .pending_o (pend)
  );

  assign granted = ~I_BUSAKn;

`ifdef MARIO_OBJDMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  assign abort = (state_q == ST_REQ) && !granted && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Counts consecutive ungranted REQ ticks; any other tick restarts it.
  always_ff @(posedge I_CLK_48M or posedge I_RESET) begin
    if (I_RESET) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (I_CEN_6M) begin
      if (state_q == ST_REQ && !granted) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        tmo_q <= '0;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end

  assign O_ERR = err_q;
`else
  assign abort = 1'b0;
  assign O_ERR = 1'b0;
`endif

  always_ff @(posedge I_CLK_48M or posedge I_RESET) begin
    if (I_RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      cpu_a_q   <= '0;
      busrq_n_q <= 1'b1;
      rd_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      cpu_a_q   <= cpu_a_d;
      busrq_n_q <= busrq_n_d;
      rd_n_q    <= rd_n_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    cpu_a_d   = cpu_a_q;
    busrq_n_d = busrq_n_q;
    rd_n_d    = rd_n_q;
    done_d    = 1'b0;
    pend_clr  = 1'b0;
    if (I_CEN_6M) begin
      case (state_q)
        ST_IDLE: begin
          if (pend) begin
            pend_clr  = 1'b1;
            idx_d     = '0;
            busrq_n_d = 1'b0;
            state_d   = ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort) begin
            busrq_n_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (granted) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!granted) begin
            state_d = ST_REQ;
          end else begin
            cpu_a_d = SRC_BASE + 16'(idx_q);
            rd_n_d  = 1'b0;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          rd_n_d = 1'b1;
          if (!granted) begin
            state_d = ST_REQ;
          end else begin
            data_d  = I_CPU_DI;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Losing the bus here drops the write; the byte is fetched again on resume.
          if (!granted) begin
            state_d = ST_REQ;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ADDR;
          end
        end
        ST_DONE: begin
          busrq_n_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
        default: begin
          busrq_n_d = 1'b1;
          rd_n_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  assign O_BUSRQn    = busrq_n_q;
  assign O_CPU_A     = cpu_a_q;
  assign O_CPU_RDn   = rd_n_q;
  assign O_OBJDMA_A  = idx_q;
  assign O_OBJDMA_D  = data_q;
  assign O_OBJDMA_CE = I_CEN_6M && (state_q == ST_WRITE) && granted;
  assign O_BUSY      = (state_q != ST_IDLE);
  assign O_DONE      = done_q;

endmodule
`default_nettype wire
